// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet header constants, classes and the queued descriptor type
package eth_pkg;
  localparam logic [15:0] ETHERTYPE_IPV4    = 16'h0800;
  localparam logic [15:0] ETHERTYPE_IPV6    = 16'h86DD;
  localparam logic [15:0] ETHERTYPE_ARP     = 16'h0806;
  localparam logic [15:0] ETHERTYPE_VLAN    = 16'h8100;
  localparam logic [15:0] ETH_MIN_ETHERTYPE = 16'h0600;
  localparam logic [47:0] MAC_BCAST         = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    CLS_OTHER = 3'd0,
    CLS_IPV4  = 3'd1,
    CLS_IPV6  = 3'd2,
    CLS_ARP   = 3'd3,
    CLS_VLAN  = 3'd4,
    CLS_LLC   = 3'd5
  } eth_class_t;

  typedef struct packed {
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    eth_class_t  cls;
    logic        bcast;
    logic        mcast;
  } eth_desc_t;

  function automatic eth_class_t eth_classify(input logic [15:0] t);
    return t == ETHERTYPE_IPV4    ? CLS_IPV4 :
           t == ETHERTYPE_IPV6    ? CLS_IPV6 :
           t == ETHERTYPE_ARP     ? CLS_ARP  :
           t == ETHERTYPE_VLAN    ? CLS_VLAN :
           t <  ETH_MIN_ETHERTYPE ? CLS_LLC  : CLS_OTHER;
  endfunction
endpackage

// File: rtl/eth_desc_fifo.sv
// eth_desc_fifo: synchronous descriptor FIFO; a push while full is taken only alongside a pop
module eth_desc_fifo
  import eth_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  eth_desc_t                din,
  output eth_desc_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  eth_desc_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/eth_header_filter.sv
// eth_header_filter: address filter + EtherType classifier feeding a descriptor FIFO
// ETH_FILTER_STATS_EN enables the accept/drop/overflow counters; otherwise they read 0.
module eth_header_filter
  import eth_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [47:0]      dst_mac,
  input  logic [47:0]      src_mac,
  input  logic [15:0]      eth_type,
  input  logic             hdr_valid,
  input  logic [47:0]      local_mac,
  input  logic             promisc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      out_src_mac,
  output logic [15:0]      out_eth_type,
  output logic [2:0]       out_class,
  output logic             out_bcast,
  output logic             out_mcast,
  output logic [CNT_W-1:0] accept_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);
  logic      s1_valid, s1_hit, bcast, pop, room, push, full, empty;
  eth_desc_t s1_desc, head;
  assign bcast = dst_mac == MAC_BCAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_desc  <= '0;
    end else begin
      s1_valid <= hdr_valid;
      s1_hit   <= promisc | (dst_mac == local_mac) | bcast | dst_mac[40];
      s1_desc  <= '{src_mac: src_mac, eth_type: eth_type, cls: eth_classify(eth_type),
                    bcast: bcast, mcast: dst_mac[40] & ~bcast};
    end
  end
  // a pop in the same cycle frees the slot for the incoming descriptor
  assign pop  = !empty && out_ready;
  assign room = !full || pop;
  assign push = s1_valid && s1_hit && room;
  eth_desc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (s1_desc),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count ()
  );
  assign out_valid    = !empty;
  assign out_src_mac  = head.src_mac;
  assign out_eth_type = head.eth_type;
  assign out_class    = head.cls;
  assign out_bcast    = head.bcast;
  assign out_mcast    = head.mcast;
`ifdef ETH_FILTER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_cnt <= '0;
      drop_cnt   <= '0;
      ovf_cnt    <= '0;
    end else begin
      if (push && accept_cnt != '1) accept_cnt <= accept_cnt + CNT_W'(1);
      if (s1_valid && !s1_hit && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      if (s1_valid && s1_hit && !room && ovf_cnt != '1) ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end
`else
  assign accept_cnt = '0;
  assign drop_cnt   = '0;
  assign ovf_cnt    = '0;
`endif
endmodule

// File: tb/tb_eth_header_filter.sv
// tb_eth_header_filter: directed and random checks against a queue-based frame model
module tb_eth_header_filter;
  import eth_pkg::*;
  localparam int DEPTH = 4;
  localparam int CW = 16;
`ifdef ETH_FILTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BC    = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] SRCB  = 48'h0A_00_00_00_10_00;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [47:0] dst_mac = '0, src_mac = '0, local_mac = '0;
  logic [15:0] eth_type = '0;
  logic hdr_valid = 1'b0, promisc = 1'b0, out_ready = 1'b0;
  logic out_valid, out_bcast, out_mcast;
  logic [47:0] out_src_mac;
  logic [15:0] out_eth_type;
  logic [2:0] out_class;
  logic [CW-1:0] accept_cnt, drop_cnt, ovf_cnt;

  always #5 clk = ~clk;

  eth_header_filter #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .dst_mac(dst_mac), .src_mac(src_mac), .eth_type(eth_type),
    .hdr_valid(hdr_valid), .local_mac(local_mac), .promisc(promisc), .out_valid(out_valid),
    .out_ready(out_ready), .out_src_mac(out_src_mac), .out_eth_type(out_eth_type),
    .out_class(out_class), .out_bcast(out_bcast), .out_mcast(out_mcast),
    .accept_cnt(accept_cnt), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt)
  );

  typedef struct packed {
    logic [47:0] src;
    logic [15:0] typ;
    logic [2:0]  cls;
    logic        bc;
    logic        mc;
  } d_t;

  int checks = 0, errors = 0;
  d_t q[$];
  bit p_valid = 0, p_hit = 0;
  d_t p_d = '0;
  int n_acc = 0, n_drop = 0, n_ovf = 0;

  function automatic logic [2:0] ref_class(input logic [15:0] t);
    case (t)
      16'h0800: return 3'd1;
      16'h86DD: return 3'd2;
      16'h0806: return 3'd3;
      16'h8100: return 3'd4;
      default:  return t < 16'h0600 ? 3'd5 : 3'd0;
    endcase
  endfunction

  function automatic logic [CW-1:0] sat(input int n);
    if (!STATS) return '0;
    return n >= 2**CW - 1 ? '1 : CW'(n);
  endfunction

  function automatic logic [3*CW-1:0] cnt_exp();
    return {sat(n_acc), sat(n_drop), sat(n_ovf)};
  endfunction

  function automatic d_t head_exp();
    return q.size() != 0 ? q[0] : '0;
  endfunction

  // One clock: drive inputs, advance the frame-level model, then sample just after the edge.
  task automatic cycle(input bit hv, input logic [47:0] dst, input logic [47:0] src,
                       input logic [15:0] typ, input bit rdy);
    bit pop, full, bc;
    hdr_valid = hv; dst_mac = dst; src_mac = src; eth_type = typ; out_ready = rdy;
    full = q.size() == DEPTH;
    pop = q.size() != 0 && rdy;
    if (pop) void'(q.pop_front());
    if (p_valid) begin
      if (!p_hit) n_drop++;
      else if (!full || pop) begin q.push_back(p_d); n_acc++; end
      else n_ovf++;
    end
    bc = dst == BC;
    p_valid = hv;
    p_hit = promisc || dst == local_mac || bc || dst[40];
    p_d = '{src, typ, ref_class(typ), bc, dst[40] && !bc};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, '0, '0, '0, rdy);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_src_mac, out_eth_type, out_class, out_bcast, out_mcast} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b src=%h type=%h cls=%0d want all zero",
               out_valid, out_src_mac, out_eth_type, out_class);
    end
    checks++;
    if ({accept_cnt, drop_cnt, ovf_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", accept_cnt, drop_cnt, ovf_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unicast();
    local_mac = LOCAL; promisc = 1'b0;
    cycle(1'b1, LOCAL, 48'hA1_B2_C3_D4_E5_F6, 16'h0800, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL unicast_latency_n1 out_valid=%b want 0", out_valid);
    end
    idle(1'b1);
    checks++;
    if ({out_valid, out_class, out_bcast, out_mcast, out_src_mac, out_eth_type} !==
        {1'b1, 3'd1, 1'b0, 1'b0, 48'hA1_B2_C3_D4_E5_F6, 16'h0800}) begin
      errors++;
      $display("FAIL unicast_desc got v=%b cls=%0d bc=%b mc=%b src=%h type=%h want v=1 cls=1 bc=0 mc=0 src=a1b2c3d4e5f6 type=0800",
               out_valid, out_class, out_bcast, out_mcast, out_src_mac, out_eth_type);
    end
    checks++;
    if ({accept_cnt, drop_cnt, ovf_cnt} !== cnt_exp() || accept_cnt !== (STATS ? CW'(1) : CW'(0))) begin
      errors++; $display("FAIL unicast_cnt got acc=%0d drop=%0d ovf=%0d", accept_cnt, drop_cnt, ovf_cnt);
    end
    idle(1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL unicast_pop out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_bcast_mcast();
    cycle(1'b1, BC, 48'h11_22_33_44_55_66, 16'h0806, 1'b1);
    idle(1'b1);
    checks++;
    if ({out_valid, out_class, out_bcast, out_mcast} !== {1'b1, 3'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL bcast_desc got v=%b cls=%0d bc=%b mc=%b want v=1 cls=3 bc=1 mc=0",
               out_valid, out_class, out_bcast, out_mcast);
    end
    cycle(1'b1, 48'h01_00_5E_00_00_01, 48'h66_55_44_33_22_11, 16'h86DD, 1'b1);
    idle(1'b1);
    checks++;
    if ({out_valid, out_class, out_bcast, out_mcast, out_src_mac} !==
        {1'b1, 3'd2, 1'b0, 1'b1, 48'h66_55_44_33_22_11}) begin
      errors++;
      $display("FAIL mcast_desc got v=%b cls=%0d bc=%b mc=%b src=%h want v=1 cls=2 bc=0 mc=1 src=665544332211",
               out_valid, out_class, out_bcast, out_mcast, out_src_mac);
    end
    idle(1'b1);
  endtask

  task automatic test_drop();
    promisc = 1'b0;
    cycle(1'b1, 48'h02_00_00_00_00_99, 48'h0B_0B_0B_0B_0B_0B, 16'h0800, 1'b1);
    idle(1'b1);
    idle(1'b1);
    checks++;
    if (out_valid !== 1'b0 || {accept_cnt, drop_cnt, ovf_cnt} !== cnt_exp()) begin
      errors++;
      $display("FAIL drop got v=%b drop=%0d want v=0 drop=%0d", out_valid, drop_cnt, sat(n_drop));
    end
    promisc = 1'b1;
    cycle(1'b1, 48'h02_00_00_00_00_99, 48'h0C_0C_0C_0C_0C_0C, 16'h0800, 1'b1);
    promisc = 1'b0;
    idle(1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_src_mac !== 48'h0C_0C_0C_0C_0C_0C) begin
      errors++;
      $display("FAIL promisc_accept got v=%b src=%h want v=1 src=0c0c0c0c0c0c", out_valid, out_src_mac);
    end
    idle(1'b1);
  endtask

  task automatic test_class();
    logic [15:0] types [3] = '{16'h05DC, 16'h88CC, 16'h8100};
    logic [2:0]  cls   [3] = '{3'd5, 3'd0, 3'd4};
    promisc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 48'h02_44_00_00_00_07, SRCB + 48'(i), types[i], 1'b1);
      idle(1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_class !== cls[i]) begin
        errors++;
        $display("FAIL class_%h got v=%b cls=%0d want v=1 cls=%0d", types[i], out_valid, out_class, cls[i]);
      end
      idle(1'b1);
    end
    promisc = 1'b0;
  endtask

  task automatic test_overflow();
    int pops = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, LOCAL, SRCB + 48'(i), 16'h0800, 1'b0);
    idle(1'b0);
    idle(1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_src_mac !== SRCB) begin
      errors++; $display("FAIL ovf_head got v=%b src=%h want v=1 src=%h", out_valid, out_src_mac, SRCB);
    end
    checks++;
    if ({accept_cnt, drop_cnt, ovf_cnt} !== cnt_exp() || n_ovf != 2) begin
      errors++;
      $display("FAIL ovf_cnt got acc=%0d ovf=%0d want acc=%0d ovf=%0d", accept_cnt, ovf_cnt, sat(n_acc), sat(n_ovf));
    end
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        checks++;
        if (out_src_mac !== SRCB + 48'(pops)) begin
          errors++; $display("FAIL ovf_order got src=%h want %h", out_src_mac, SRCB + 48'(pops));
        end
        pops++;
      end
      idle(1'b1);
    end
    checks++;
    if (pops != 4 || out_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_drain got pops=%0d v=%b want pops=4 v=0", pops, out_valid);
    end
  endtask

  task automatic test_full_pop();
    int pops = 0;
    for (int i = 0; i < 4; i++) cycle(1'b1, LOCAL, SRCB + 48'(i), 16'h0800, 1'b0);
    idle(1'b0);
    cycle(1'b1, LOCAL, SRCB + 48'd4, 16'h86DD, 1'b0);
    idle(1'b1);
    idle(1'b0);
    checks++;
    if ({accept_cnt, drop_cnt, ovf_cnt} !== cnt_exp() || out_src_mac !== SRCB + 48'd1) begin
      errors++;
      $display("FAIL fullpop_cnt got acc=%0d ovf=%0d src=%h want acc=%0d ovf=%0d src=%h",
               accept_cnt, ovf_cnt, out_src_mac, sat(n_acc), sat(n_ovf), SRCB + 48'd1);
    end
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        checks++;
        if (out_src_mac !== SRCB + 48'(pops + 1)) begin
          errors++; $display("FAIL fullpop_order got src=%h want %h", out_src_mac, SRCB + 48'(pops + 1));
        end
        pops++;
      end
      idle(1'b1);
    end
    checks++;
    if (pops != 4 || out_valid !== 1'b0) begin
      errors++; $display("FAIL fullpop_count got pops=%0d v=%b want pops=4 v=0", pops, out_valid);
    end
  endtask

  task automatic test_random();
    logic [15:0] types [7] = '{16'h0800, 16'h86DD, 16'h0806, 16'h8100, 16'h05DC, 16'h88CC, 16'h0600};
    logic [47:0] dst;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) promisc = 1'($urandom);
      if ($urandom_range(0, 15) == 0) local_mac = $urandom_range(0, 1) ? LOCAL : 48'h02_00_00_00_00_22;
      case ($urandom_range(0, 3))
        0: dst = LOCAL;
        1: dst = BC;
        2: dst = 48'h01_00_5E_00_00_00 | 48'($urandom_range(0, 255));
        default: begin dst = {16'($urandom), 32'($urandom)}; dst[40] = 1'b0; end
      endcase
      cycle(1'($urandom_range(0, 3) != 0), dst, {16'($urandom), 32'($urandom)},
            types[$urandom_range(0, 6)], $urandom_range(0, 2) != 0);
      checks++;
      if (out_valid !== (q.size() != 0) ||
          (q.size() != 0 && {out_src_mac, out_eth_type, out_class, out_bcast, out_mcast} !== head_exp())) begin
        errors++;
        $display("FAIL random_head cyc=%0d got v=%b desc=%h want v=%b desc=%h", n, out_valid,
                 {out_src_mac, out_eth_type, out_class, out_bcast, out_mcast}, q.size() != 0, head_exp());
      end
      checks++;
      if ({accept_cnt, drop_cnt, ovf_cnt} !== cnt_exp()) begin
        errors++;
        $display("FAIL random_cnt cyc=%0d got %0d/%0d/%0d want %0d/%0d/%0d", n, accept_cnt, drop_cnt,
                 ovf_cnt, sat(n_acc), sat(n_drop), sat(n_ovf));
      end
    end
    promisc = 1'b0;
    local_mac = LOCAL;
    repeat (8) idle(1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, LOCAL, SRCB + 48'(i), 16'h0800, 1'b0);
    idle(1'b0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL areset_pre out_valid=%b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_src_mac, out_eth_type, out_class, out_bcast, out_mcast} !== '0 ||
        {accept_cnt, drop_cnt, ovf_cnt} !== '0) begin
      errors++;
      $display("FAIL areset_now got v=%b src=%h acc=%0d drop=%0d ovf=%0d want all zero",
               out_valid, out_src_mac, accept_cnt, drop_cnt, ovf_cnt);
    end
    q.delete();
    p_valid = 0; n_acc = 0; n_drop = 0; n_ovf = 0;
    @(negedge clk) rst_n = 1'b1;
    idle(1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL areset_post out_valid=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_bcast_mcast();
    test_drop();
    test_class();
    test_overflow();
    test_full_pop();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
